// File: rtl/case_1_mul_pkg.sv
// Shared constants and helpers for the pipelined multiplier: result range-reduction
// modes and the full-product width rule.
package case_1_mul_pkg;

  localparam int MODE_TRUNC = 0;
  localparam int MODE_SAT   = 1;

  function automatic int prod_width(input int w0, input int w1);
    return w0 + w1;
  endfunction

endpackage

// File: rtl/case_1_mul_pipe_stage.sv
// One pipeline register: a data word plus its valid bit, advancing only when ce is high.
module case_1_mul_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  input  logic         valid_d,
  input  logic [W-1:0] data_d,
  output logic         valid_q,
  output logic [W-1:0] data_q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (ce) begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/case_1_mul_pipe.sv
// Pipelined multiplier with valid/ready flow control: multiply in the first register
// stage, truncate or saturate to the output width in the last.
module case_1_mul_pipe
  import case_1_mul_pkg::*;
#(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 3,
  parameter int din0_WIDTH = 14,
  parameter int din1_WIDTH = 12,
  parameter int dout_WIDTH = 26,
  parameter int SIGNED0    = 1,
  parameter int SIGNED1    = 1,
  parameter int SAT_MODE   = 0
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  ovf,
  output logic                  busy
);

  localparam int P         = prod_width(din0_WIDTH, din1_WIDTH);
  localparam int DW        = dout_WIDTH;
  localparam bit IS_SIGNED = (SIGNED0 != 0) || (SIGNED1 != 0);
  localparam bit DO_SAT    = (SAT_MODE == MODE_SAT);

  // Handshake: a word moves on valid && ready at either port. The whole pipe,
  // bubbles included, advances only when the output slot is empty or being taken,
  // so in_ready is that same enable and all stages hold together on a stall.
  logic                        ce;
  logic [NUM_STAGE:0]          vld;
  logic [NUM_STAGE-1:0][P-1:0] pdat;
  logic [P-1:0]                a_ext, b_ext, red_in;
  logic [DW:0]                 red_out, res_q;
  logic                        unused_cfg;

  assign unused_cfg = ID[0] ^ DO_SAT;

  assign ce        = out_ready | ~out_valid;
  assign in_ready  = ce;
  assign vld[0]    = in_valid;
  assign out_valid = vld[NUM_STAGE];
  assign busy      = |vld[NUM_STAGE:1];
  assign dout      = res_q[DW-1:0];
  assign ovf       = res_q[DW];

  always_comb begin
    a_ext = P'(din0);
    b_ext = P'(din1);
    if (SIGNED0 != 0) a_ext = P'($signed(din0));
    if (SIGNED1 != 0) b_ext = P'($signed(din1));
  end

  // Both operands are extended to the full product width, so the low P bits of the
  // modular product are exact for every signed/unsigned mix.
  assign pdat[0] = a_ext * b_ext;
  assign red_in  = pdat[NUM_STAGE-1];

  if (P <= DW) begin : g_fit
    always_comb begin
      red_out = {1'b0, DW'(red_in)};
      if (IS_SIGNED) red_out = {1'b0, DW'($signed(red_in))};
    end
  end else begin : g_reduce
    logic [P-DW-1:0] hi;
    logic            fits;

    always_comb begin
      hi   = red_in[P-1:DW];
      fits = (hi == '0);
      if (IS_SIGNED) fits = (hi == {(P-DW){red_in[DW-1]}});
      red_out = {~fits, red_in[DW-1:0]};
      if (!fits && DO_SAT) begin
        if (!IS_SIGNED)      red_out[DW-1:0] = '1;
        else if (red_in[P-1]) red_out[DW-1:0] = {1'b1, {(DW-1){1'b0}}};
        else                  red_out[DW-1:0] = {1'b0, {(DW-1){1'b1}}};
      end
    end
  end

  for (genvar i = 0; i < NUM_STAGE; i++) begin : g_stage
    if (i == NUM_STAGE - 1) begin : g_last
      case_1_mul_pipe_stage #(.W(DW + 1)) u_stage (
        .clk     (ap_clk),
        .rst_n   (ap_rst_n),
        .ce      (ce),
        .valid_d (vld[i]),
        .data_d  (red_out),
        .valid_q (vld[i+1]),
        .data_q  (res_q)
      );
    end else begin : g_mid
      case_1_mul_pipe_stage #(.W(P)) u_stage (
        .clk     (ap_clk),
        .rst_n   (ap_rst_n),
        .ce      (ce),
        .valid_d (vld[i]),
        .data_d  (pdat[i]),
        .valid_q (vld[i+1]),
        .data_q  (pdat[i+1])
      );
    end
  end

endmodule

// File: tb/tb_case_1_mul_pipe.sv
// Bench for case_1_mul_pipe: four configurations share one stimulus stream; each has
// its own expected queue, drained by a monitor whenever a result is taken.
module tb_case_1_mul_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [13:0] din0;
  logic [11:0] din1;

  logic        rdy_d, ov_d, ovf_d, busy_d;
  logic [25:0] dout_d;
  logic        rdy_s, ov_s, ovf_s, busy_s;
  logic [15:0] dout_s;
  logic        rdy_t, ov_t, ovf_t, busy_t;
  logic [15:0] dout_t;
  logic        rdy_u, ov_u, ovf_u, busy_u;
  logic [25:0] dout_u;

  int checks   = 0;
  int failures = 0;

  logic [26:0] exp_d_q[$];
  logic [16:0] exp_s_q[$];
  logic [16:0] exp_t_q[$];
  logic [26:0] exp_u_q[$];

  // Directed vectors; expected {dout, ovf} per configuration worked out by hand:
  // d = defaults, s = 16-bit saturate, t = 16-bit truncate, u = both unsigned.
  int va[8] = '{-8192, 300, -300, 16383, 100, -8192, -128, 128};
  int vb[8] = '{-2048, 200, 200, 4095, -50, 2047, 256, 256};
  int ed[8] = '{16777216, 60000, 67048864, 1, 67103864, 50339840, 67076096, 32768};
  int od[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
  int es[8] = '{32767, 32767, 32768, 1, 60536, 32768, 32768, 32767};
  int os[8] = '{1, 1, 1, 0, 0, 1, 0, 1};
  int et[8] = '{0, 60000, 5536, 1, 60536, 8192, 32768, 32768};
  int ot[8] = '{1, 1, 1, 0, 0, 1, 0, 1};
  int eu[8] = '{16777216, 60000, 3216800, 67088385, 404600, 16769024, 4161536, 32768};
  int ou[8] = '{0, 0, 0, 0, 0, 0, 0, 0};

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  case_1_mul_pipe u_def (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_d),
    .din0(din0), .din1(din1), .out_valid(ov_d), .out_ready(out_ready),
    .dout(dout_d), .ovf(ovf_d), .busy(busy_d)
  );

  case_1_mul_pipe #(.dout_WIDTH(16), .SAT_MODE(1)) u_sat (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_s),
    .din0(din0), .din1(din1), .out_valid(ov_s), .out_ready(out_ready),
    .dout(dout_s), .ovf(ovf_s), .busy(busy_s)
  );

  case_1_mul_pipe #(.dout_WIDTH(16), .SAT_MODE(0)) u_trn (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_t),
    .din0(din0), .din1(din1), .out_valid(ov_t), .out_ready(out_ready),
    .dout(dout_t), .ovf(ovf_t), .busy(busy_t)
  );

  case_1_mul_pipe #(.SIGNED0(0), .SIGNED1(0)) u_uns (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_u),
    .din0(din0), .din1(din1), .out_valid(ov_u), .out_ready(out_ready),
    .dout(dout_u), .ovf(ovf_u), .busy(busy_u)
  );

  // ---------------- check helpers ----------------
  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got an output with nothing expected", name);
  endtask

  // ---------------- driver ----------------
  task automatic send(input int idx);
    int guard;
    logic [31:0] e;
    @(negedge clk);
    din0     = 14'(va[idx]);
    din1     = 12'(vb[idx]);
    in_valid = 1'b1;
    #1;
    guard = 0;
    while (!rdy_d && guard < 200) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (guard >= 200) compare("in_ready_timeout", 32'(rdy_d), 32'd1);
    e = 32'(ed[idx]); exp_d_q.push_back({od[idx][0], e[25:0]});
    e = 32'(es[idx]); exp_s_q.push_back({os[idx][0], e[15:0]});
    e = 32'(et[idx]); exp_t_q.push_back({ot[idx][0], e[15:0]});
    e = 32'(eu[idx]); exp_u_q.push_back({ou[idx][0], e[25:0]});
    @(posedge clk);
  endtask

  task automatic idle_in();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [26:0] e27;
    logic [16:0] e17;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_ready) begin
        if (ov_d) begin
          if (exp_d_q.size() == 0) unexpected("out_def");
          else begin e27 = exp_d_q.pop_front(); compare("out_def", 32'({ovf_d, dout_d}), 32'(e27)); end
        end
        if (ov_s) begin
          if (exp_s_q.size() == 0) unexpected("out_sat16");
          else begin e17 = exp_s_q.pop_front(); compare("out_sat16", 32'({ovf_s, dout_s}), 32'(e17)); end
        end
        if (ov_t) begin
          if (exp_t_q.size() == 0) unexpected("out_trunc16");
          else begin e17 = exp_t_q.pop_front(); compare("out_trunc16", 32'({ovf_t, dout_t}), 32'(e17)); end
        end
        if (ov_u) begin
          if (exp_u_q.size() == 0) unexpected("out_unsigned");
          else begin e27 = exp_u_q.pop_front(); compare("out_unsigned", 32'({ovf_u, dout_u}), 32'(e27)); end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    int order[10] = '{0, 1, 2, 3, 4, 5, 6, 7, 1, 2};
    logic [25:0] held;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    din0      = '0;
    din1      = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    compare("rst_out_valid", 32'(ov_d), 32'd0);
    compare("rst_busy", 32'({busy_d, busy_s, busy_t, busy_u}), 32'd0);
    compare("rst_dout", 32'(dout_d), 32'd0);
    compare("rst_ovf", 32'(ovf_d), 32'd0);
    compare("rst_in_ready", 32'({rdy_d, rdy_s, rdy_t, rdy_u}), 32'hF);

    // Latency: edge count from the accepting edge to out_valid.
    send(0);
    lat = 0;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      if (k > 1) @(posedge clk);
      #1;
      if (k == 1) in_valid = 1'b0;
      if (ov_d) lat = k;
    end
    compare("latency", 32'(lat), 32'd3);
    repeat (3) @(posedge clk);

    for (int i = 1; i < 8; i++) begin
      send(i);
      idle_in();
      repeat (4) @(posedge clk);
    end

    // Back-to-back stream with a 4-cycle downstream stall.
    fork
      begin
        for (int i = 0; i < 10; i++) send(order[i]);
        idle_in();
      end
      begin
        repeat (5) @(negedge clk);
        out_ready = 1'b0;
        #1;
        held = dout_d;
        for (int k = 0; k < 4; k++) begin
          if (k > 0) begin
            @(negedge clk);
            #1;
            compare("stall_dout_stable", 32'(dout_d), 32'(held));
          end
          compare("stall_in_ready", 32'(rdy_d), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
    join

    for (int k = 0; k < 100 && (exp_d_q.size() + exp_s_q.size() + exp_t_q.size() + exp_u_q.size()) != 0; k++)
      @(posedge clk);
    compare("drain_def", 32'(exp_d_q.size()), 32'd0);
    compare("drain_sat16", 32'(exp_s_q.size()), 32'd0);
    compare("drain_trunc16", 32'(exp_t_q.size()), 32'd0);
    compare("drain_unsigned", 32'(exp_u_q.size()), 32'd0);

    // Reset with three results in flight: all must vanish.
    @(negedge clk);
    out_ready = 1'b0;
    send(1);
    send(2);
    send(3);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    compare("inflight_busy", 32'(busy_d), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_d_q.delete();
    exp_s_q.delete();
    exp_t_q.delete();
    exp_u_q.delete();
    #1;
    compare("flush_out_valid", 32'({ov_d, ov_s, ov_t, ov_u}), 32'd0);
    compare("flush_busy", 32'({busy_d, busy_s, busy_t, busy_u}), 32'd0);
    compare("flush_in_ready", 32'(rdy_d), 32'd1);
    out_ready = 1'b1;
    repeat (10) @(posedge clk);

    send(4);
    idle_in();
    for (int k = 0; k < 50 && exp_d_q.size() != 0; k++) @(posedge clk);
    repeat (2) @(posedge clk);
    compare("post_reset_drain", 32'(exp_d_q.size() + exp_s_q.size() + exp_t_q.size() + exp_u_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
